mem_arbiter: RTL

Arbitrates one single-port synchronous RAM between the instruction-fetch port and the load/store data port of the riscv core. Only one transaction is outstanding at a time. Data has fixed priority, with a starvation guard that protects fetch. Drives a hold flag into ctrl so the pipeline stalls while a data access is pending.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the fetch port
// and the load/store data port. One transaction in flight at a time; data has
// fixed priority except when its consecutive-grant streak has starved a
// waiting fetch. Grants, RAM strobes and read data are combinational so a
// request can be accepted in the cycle it is presented.
module mem_arbiter #(
    parameter int RD_LAT     = 1,  // RAM read latency in cycles (1..8)
    parameter int MAX_STREAK = 4   // data grants allowed while fetch waits (1..15)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        hold_flag_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT    = 3'(RD_LAT - 1);
    localparam logic [3:0] STREAK_MAX  = 4'(MAX_STREAK);
    localparam logic [3:0] STREAK_SAT  = 4'hF;
    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic        owner_r;
    logic        owner_nxt_s;
    logic [3:0]  streak_r;
    logic [3:0]  streak_nxt_s;

    logic        rsp_s;
    logic        window_s;
    logic        fetch_win_s;
    logic        data_win_s;
    logic        read_gnt_s;

    // Grant window and fixed-priority arbitration with the fetch starvation guard.
    // Reset gates every grant so outputs sit at their reset values while rst is high.
    always_comb begin
        rsp_s       = 1'b0;
        window_s    = 1'b0;
        fetch_win_s = 1'b0;
        data_win_s  = 1'b0;
        if (rst) begin
            rsp_s    = 1'b0;
            window_s = 1'b0;
        end else begin
            rsp_s    = (state_r == ST_WAIT) && (cnt_r == 3'd0);
            window_s = (state_r == ST_IDLE) || rsp_s;
        end
        if (window_s) begin
            fetch_win_s = if_req_i && (!d_req_i || (streak_r == STREAK_MAX));
            data_win_s  = d_req_i && !fetch_win_s;
        end else begin
            fetch_win_s = 1'b0;
            data_win_s  = 1'b0;
        end
    end

    // Drive RAM strobes, grants, read-data steering and the pipeline hold flag.
    always_comb begin
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0000;
        ram_addr_o  = 32'h0000_0000;
        ram_wdata_o = 32'h0000_0000;
        if_rvalid_o = 1'b0;
        if_rdata_o  = 32'h0000_0000;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = 32'h0000_0000;
        hold_flag_o = 1'b0;

        if (data_win_s) begin
            d_gnt_o    = 1'b1;
            ram_en_o   = 1'b1;
            ram_addr_o = d_addr_i;
            if (d_we_i) begin
                ram_we_o    = d_sel_i;
                ram_wdata_o = d_wdata_i;
            end else begin
                ram_we_o    = 4'b0000;
                ram_wdata_o = 32'h0000_0000;
            end
        end else if (fetch_win_s) begin
            if_gnt_o   = 1'b1;
            ram_en_o   = 1'b1;
            ram_addr_o = if_addr_i;
        end else begin
            ram_en_o = 1'b0;
        end

        if (rsp_s && (owner_r == OWNER_DATA)) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = ram_rdata_i;
        end else if (rsp_s) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = ram_rdata_i;
        end else begin
            if_rvalid_o = 1'b0;
            d_rvalid_o  = 1'b0;
        end

        if (rst) begin
            hold_flag_o = 1'b0;
        end else begin
            hold_flag_o = (d_req_i && !data_win_s) ||
                          ((state_r == ST_WAIT) && (owner_r == OWNER_DATA) && !rsp_s);
        end
    end

    // Next-state: a read grant (also from the response cycle) reloads the latency
    // counter; otherwise count down and drop back to IDLE once the data is delivered.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        owner_nxt_s = owner_r;
        read_gnt_s  = fetch_win_s || (data_win_s && !d_we_i);
        if (read_gnt_s) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
            owner_nxt_s = data_win_s ? OWNER_DATA : OWNER_FETCH;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // Streak of data grants taken while fetch was waiting; saturates, and any
    // fetch grant or idle fetch port resets it.
    always_comb begin
        streak_nxt_s = streak_r;
        if (!if_req_i) begin
            streak_nxt_s = 4'd0;
        end else if (fetch_win_s) begin
            streak_nxt_s = 4'd0;
        end else if (data_win_s && (streak_r != STREAK_SAT)) begin
            streak_nxt_s = streak_r + 4'd1;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // State registers; reset discards any outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            owner_r  <= OWNER_FETCH;
            streak_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            owner_r  <= owner_nxt_s;
            streak_r <= streak_nxt_s;
        end
    end

endmodule
